// File: rtl/store_align_buffer_pkg.sv
// rtl/store_align_buffer_pkg.sv - shared store size codes and byte strobe constants
package store_align_buffer_pkg;

    typedef enum logic [1:0] {
        SIZE_B = 2'b00,
        SIZE_H = 2'b01,
        SIZE_W = 2'b10,
        SIZE_X = 2'b11
    } storeSizeT;

    localparam logic [3:0] STRB_B   = 4'b0001;
    localparam logic [3:0] STRB_HLO = 4'b0011;
    localparam logic [3:0] STRB_HHI = 4'b1100;
    localparam logic [3:0] STRB_W   = 4'b1111;

endpackage

// File: rtl/store_align_buffer_if.sv
// rtl/store_align_buffer_if.sv - store request and data memory handshake bundle
interface store_align_buffer_if #(
    parameter int ADDR_W = 32
) ();
    logic              req_valid;
    logic              req_ready;
    logic [ADDR_W-1:0] req_addr;
    logic [1:0]        req_size;
    logic [31:0]       req_data;

    logic              mem_valid;
    logic              mem_ready;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wdata;
    logic [3:0]        mem_wstrb;

    modport master (
        output req_valid, req_addr, req_size, req_data, mem_ready,
        input  req_ready, mem_valid, mem_addr, mem_wdata, mem_wstrb
    );

    modport slave (
        input  req_valid, req_addr, req_size, req_data, mem_ready,
        output req_ready, mem_valid, mem_addr, mem_wdata, mem_wstrb
    );
endinterface

// File: rtl/store_align_buffer_lane_gen.sv
// rtl/store_align_buffer_lane_gen.sv - lane replication, byte strobes and misalign detect
module store_lane_gen
    import store_align_buffer_pkg::*;
(
    input  logic [1:0]  addrLo,
    input  logic [1:0]  size,
    input  logic [31:0] data,
    output logic [31:0] laneData,
    output logic [3:0]  laneStrb,
    output logic        misalign
);

    always_comb begin
        laneData = data;
        laneStrb = STRB_W;
        misalign = 1'b0;
        case (storeSizeT'(size))
            SIZE_B: begin
                laneData = {4{data[7:0]}};
                laneStrb = STRB_B << addrLo;
            end
            SIZE_H: begin
                laneData = {2{data[15:0]}};
                laneStrb = addrLo[1] ? STRB_HHI : STRB_HLO;
                misalign = addrLo[0];
            end
            SIZE_W: misalign = (addrLo != 2'b00);
            default: misalign = 1'b1;
        endcase
    end

endmodule

// File: rtl/store_align_buffer.sv
// rtl/store_align_buffer.sv - in-order store buffer with alignment checks and flush
module store_align_buffer
    import store_align_buffer_pkg::*;
#(
    parameter int DEPTH  = 4,
    parameter int ADDR_W = 32
) (
    input  logic                   clk,
    input  logic                   rst,
    store_align_buffer_if.slave    bus,
    input  logic                   flush,
    output logic                   ades,
    output logic [ADDR_W-1:0]      ades_addr,
    output logic [$clog2(DEPTH):0] count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL = CNT_W'(DEPTH);

    logic [ADDR_W-1:0] addrQ [DEPTH];
    logic [31:0]       dataQ [DEPTH];
    logic [3:0]        strbQ [DEPTH];
    logic [PTR_W-1:0]  headPtr;
    logic [PTR_W-1:0]  tailPtr;

    logic [31:0] laneData;
    logic [3:0]  laneStrb;
    logic        misalign;
    logic        accept;
    logic        reject;
    logic        enq;
    logic        deq;

    store_lane_gen u_lane_gen (
        .addrLo   (bus.req_addr[1:0]),
        .size     (bus.req_size),
        .data     (bus.req_data),
        .laneData (laneData),
        .laneStrb (laneStrb),
        .misalign (misalign)
    );

    assign bus.req_ready = (count != FULL);
    assign bus.mem_valid = (count != '0);
    assign bus.mem_addr  = addrQ[headPtr];
    assign bus.mem_wdata = dataQ[headPtr];
    assign bus.mem_wstrb = strbQ[headPtr];

    // A flush swallows the incoming request entirely, including its fault report
    assign accept = bus.req_valid && bus.req_ready;
    assign reject = accept && misalign && !flush;
    assign enq    = accept && !misalign && !flush;
    assign deq    = bus.mem_valid && bus.mem_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            headPtr   <= '0;
            tailPtr   <= '0;
            count     <= '0;
            ades      <= 1'b0;
            ades_addr <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                addrQ[i] <= '0;
                dataQ[i] <= '0;
                strbQ[i] <= '0;
            end
        end else begin
            ades <= reject;
            if (reject) begin
                ades_addr <= bus.req_addr;
            end
            if (enq) begin
                addrQ[tailPtr] <= {bus.req_addr[ADDR_W-1:2], 2'b00};
                dataQ[tailPtr] <= laneData;
                strbQ[tailPtr] <= laneStrb;
            end
            headPtr <= headPtr + PTR_W'(deq);
            if (flush) begin
                // Keep only the head, which may already be mid-handshake with memory
                tailPtr <= (count == '0) ? tailPtr : headPtr + 1'b1;
                count   <= (count == '0 || deq) ? '0 : CNT_W'(1);
            end else begin
                tailPtr <= tailPtr + PTR_W'(enq);
                count   <= count + CNT_W'(enq) - CNT_W'(deq);
            end
        end
    end

endmodule

// File: tb/tb_store_align_buffer.sv
// tb/tb_store_align_buffer.sv - scoreboard bench for store_align_buffer
module tb_store_align_buffer;
    import store_align_buffer_pkg::*;

    localparam int DEPTH  = 4;
    localparam int ADDR_W = 32;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
    } expT;

    logic              clk = 1'b0;
    logic              rst;
    logic              flush;
    logic              ades;
    logic [ADDR_W-1:0] ades_addr;
    logic [2:0]        count;

    expT sb[$];
    int  checks = 0;
    int  errors = 0;

    always #5 clk = ~clk;

    store_align_buffer_if #(.ADDR_W(ADDR_W)) bus ();

    store_align_buffer #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus),
        .flush     (flush),
        .ades      (ades),
        .ades_addr (ades_addr),
        .count     (count)
    );

    task automatic checkVal(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    function automatic void modelLane(input logic [31:0] addr, input logic [1:0] size,
                                      input logic [31:0] data, output expT e, output logic bad);
        e.addr = addr & 32'hFFFF_FFFC;
        e.wdata = 32'h0;
        e.wstrb = 4'h0;
        bad = 1'b0;
        case (size)
            2'b00: begin
                e.wdata = {data[7:0], data[7:0], data[7:0], data[7:0]};
                case (addr[1:0])
                    2'd0: e.wstrb = 4'b0001;
                    2'd1: e.wstrb = 4'b0010;
                    2'd2: e.wstrb = 4'b0100;
                    default: e.wstrb = 4'b1000;
                endcase
            end
            2'b01: begin
                e.wdata = {data[15:0], data[15:0]};
                e.wstrb = addr[1] ? 4'b1100 : 4'b0011;
                bad = addr[0];
            end
            2'b10: begin
                e.wdata = data;
                e.wstrb = 4'b1111;
                bad = (addr[1:0] != 2'b00);
            end
            default: bad = 1'b1;
        endcase
    endfunction

    always @(negedge clk) begin
        if (!rst && bus.mem_valid && bus.mem_ready) begin
            if (sb.size() == 0) begin
                checkVal("sb_underflow", 64'd1, 64'd0);
            end else begin
                expT e;
                e = sb.pop_front();
                checkVal("mem_addr", bus.mem_addr, e.addr);
                checkVal("mem_wdata", bus.mem_wdata, e.wdata);
                checkVal("mem_wstrb", bus.mem_wstrb, e.wstrb);
            end
        end
    end

    task automatic sendReq(input logic [31:0] addr, input logic [1:0] size, input logic [31:0] data);
        expT  e;
        logic bad;
        int   n;
        modelLane(addr, size, data, e, bad);
        bus.req_valid = 1'b1;
        bus.req_addr  = addr;
        bus.req_size  = size;
        bus.req_data  = data;
        n = 0;
        @(negedge clk);
        while (!bus.req_ready && n < 40) begin
            n++;
            @(negedge clk);
        end
        if (!bus.req_ready) checkVal("req_timeout", 64'd0, 64'd1);
        @(posedge clk);
        if (!bad) sb.push_back(e);
        #1;
        bus.req_valid = 1'b0;
    endtask

    task automatic waitIdle();
        int n;
        n = 0;
        while (count != 0 && n < 50) begin
            @(posedge clk);
            #1;
            n++;
        end
        checkVal("drain_count", count, 0);
        checkVal("sb_empty", sb.size(), 0);
    endtask

    logic [31:0] rejAddr [3];
    logic [1:0]  rejSize [3];

    initial begin
        rst           = 1'b1;
        flush         = 1'b0;
        bus.req_valid = 1'b0;
        bus.req_addr  = '0;
        bus.req_size  = SIZE_B;
        bus.req_data  = '0;
        bus.mem_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checkVal("rst_count", count, 0);
        checkVal("rst_mem_valid", bus.mem_valid, 0);
        checkVal("rst_req_ready", bus.req_ready, 1);
        checkVal("rst_ades", ades, 0);
        checkVal("rst_ades_addr", ades_addr, 0);
        checkVal("rst_mem_addr", bus.mem_addr, 0);
        checkVal("rst_mem_wdata", bus.mem_wdata, 0);
        checkVal("rst_mem_wstrb", bus.mem_wstrb, 0);
        rst = 1'b0;

        bus.mem_ready = 1'b1;
        sendReq(32'h1003, SIZE_B, 32'h0000_00A5);
        checkVal("sb_latency_valid", bus.mem_valid, 1);
        checkVal("sb_count", count, 1);
        waitIdle();

        sendReq(32'h2002, SIZE_H, 32'h0000_1234);
        waitIdle();

        rejAddr[0] = 32'h2001; rejSize[0] = SIZE_H;
        rejAddr[1] = 32'h3002; rejSize[1] = SIZE_W;
        rejAddr[2] = 32'h4000; rejSize[2] = 2'b11;
        for (int i = 0; i < 3; i++) begin
            sendReq(rejAddr[i], rejSize[i], 32'hDEAD_BEEF);
            checkVal("rej_ades", ades, 1);
            checkVal("rej_ades_addr", ades_addr, rejAddr[i]);
            checkVal("rej_count", count, 0);
            @(posedge clk);
            #1;
            checkVal("rej_ades_pulse", ades, 0);
            checkVal("rej_ades_hold", ades_addr, rejAddr[i]);
        end

        for (int i = 0; i < 4; i++) begin
            sendReq(32'h7000 + i, SIZE_B, 32'h11 * (i + 1));
        end
        waitIdle();

        bus.mem_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            sendReq(32'h100 + 4 * i, SIZE_W, 32'hC0DE_0000 + i);
        end
        checkVal("full_count", count, 4);
        checkVal("full_req_ready", bus.req_ready, 0);
        bus.req_valid = 1'b1;
        bus.req_addr  = 32'h110;
        bus.req_size  = SIZE_W;
        bus.req_data  = 32'hC0DE_0004;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            checkVal("stall_req_ready", bus.req_ready, 0);
            checkVal("stall_count", count, 4);
            checkVal("stall_head_addr", bus.mem_addr, sb[0].addr);
            checkVal("stall_head_wdata", bus.mem_wdata, sb[0].wdata);
        end
        bus.mem_ready = 1'b1;
        for (int i = 4; i < 8; i++) begin
            sendReq(32'h100 + 4 * i, SIZE_W, 32'hC0DE_0000 + i);
            checkVal("stream_count", count, 3);
        end
        waitIdle();

        bus.mem_ready = 1'b0;
        for (int i = 0; i < 3; i++) sendReq(32'h500 + 4 * i, SIZE_W, 32'hF1F1_0000 + i);
        flush = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b0;
        while (sb.size() > 1) void'(sb.pop_back());
        checkVal("flush_count", count, 1);
        checkVal("flush_head_addr", bus.mem_addr, 32'h500);
        checkVal("flush_head_wdata", bus.mem_wdata, 32'hF1F1_0000);
        for (int i = 0; i < 2; i++) sendReq(32'h600 + 4 * i, SIZE_W, 32'hF2F2_0000 + i);
        checkVal("flush2_count", count, 3);
        flush         = 1'b1;
        bus.mem_ready = 1'b1;
        bus.req_valid = 1'b1;
        bus.req_addr  = 32'h602;
        bus.req_size  = SIZE_W;
        @(posedge clk);
        #1;
        flush         = 1'b0;
        bus.req_valid = 1'b0;
        sb.delete();
        checkVal("flush_deq_count", count, 0);
        checkVal("flush_no_ades", ades, 0);

        bus.mem_ready = 1'b0;
        for (int i = 0; i < 3; i++) sendReq(32'h800 + 4 * i, SIZE_W, 32'hABCD_0000 + i);
        checkVal("pre_rst_count", count, 3);
        rst           = 1'b1;
        bus.mem_ready = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        sb.delete();
        checkVal("mid_rst_count", count, 0);
        checkVal("mid_rst_mem_valid", bus.mem_valid, 0);
        checkVal("mid_rst_mem_addr", bus.mem_addr, 0);
        checkVal("mid_rst_mem_wdata", bus.mem_wdata, 0);
        checkVal("mid_rst_mem_wstrb", bus.mem_wstrb, 0);
        checkVal("mid_rst_ades_addr", ades_addr, 0);

        sendReq(32'h9002, SIZE_H, 32'h0000_5A5A);
        waitIdle();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
